mc_datapath: RTL

- Multicycle MIPS-subset datapath, directly downstream of the multicycle control unit.
- Consumes the control unit's per-state control signals and returns opcode and zero to it.
- Holds PC, IR, MDR, A, B, ALUOut, a 32x32 register file, ALU control and ALU.
- Drives a single unified instruction/data memory with combinational read.

---
 rtl/mc_datapath_if.sv | 40 ++++
 rtl/mc_datapath.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath_if.sv
// ---------------------------------------------------------------------------
// mc_datapath_if
// Bus between the multicycle datapath and its single unified
// instruction/data memory. The memory answers reads combinationally, in the
// same cycle as the request.
//
// Signals:
//   mem_addr   32  byte address (datapath -> memory)
//   mem_wdata  32  store data (datapath -> memory)
//   mem_we      1  write strobe (datapath -> memory)
//   mem_re      1  read strobe (datapath -> memory)
//   mem_rdata  32  read data, valid in the same cycle (memory -> datapath)
//
// Modports:
//   master  the datapath side
//   slave   the memory side
// ---------------------------------------------------------------------------
interface mc_datapath_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/mc_datapath.sv
// ---------------------------------------------------------------------------
// mc_datapath
// Multicycle MIPS-subset datapath. It sits downstream of the multicycle
// control unit, takes that unit's per-state control signals, and returns
// the opcode and the ALU zero flag to it. The block holds PC, IR, MDR, A, B
// and ALUOut, a 32x32 register file, the ALU control decode and the ALU.
//
// Parameters:
//   RESET_PC   PC value loaded on reset
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high; overrides every control input
//   IorD       memory address select: 0 = PC, 1 = ALUOut
//   MemWrite   memory write request
//   MemRead    memory read request
//   MemtoReg   register write-data select: 0 = ALUOut, 1 = MDR
//   IRWrite    load IR from mem_rdata
//   PCSource   PC next-value select: 00 ALU, 01 ALUOut, 10 jump, 11 hold
//   RegDst     write-register select: 0 = rt, 1 = rd
//   RegWrite   register file write enable
//   ALUSrcA    ALU operand A select: 0 = PC, 1 = A
//   ALUSrcB    ALU operand B select: 00 B, 01 4, 10 sext, 11 sext<<2
//   PCWrite_F  final PC write enable (branch condition already folded in)
//   ALUOp      00 add, 01 sub, 10 decode from funct, 11 add
//   opcode     IR[31:26]
//   zero       current-cycle ALU result == 0
//   pc_out     current PC, for debug/trace
//   mem        memory bus (master side)
// ---------------------------------------------------------------------------
module mc_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 IorD,
    input  logic                 MemWrite,
    input  logic                 MemRead,
    input  logic                 MemtoReg,
    input  logic                 IRWrite,
    input  logic [1:0]           PCSource,
    input  logic                 RegDst,
    input  logic                 RegWrite,
    input  logic                 ALUSrcA,
    input  logic [1:0]           ALUSrcB,
    input  logic                 PCWrite_F,
    input  logic [1:0]           ALUOp,
    output logic [5:0]           opcode,
    output logic                 zero,
    output logic [31:0]          pc_out,
    mc_datapath_if.master        mem
);

    // ALU operation codes produced by the ALU control decode
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] alu_out;
    logic [31:0] rf [0:31];

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] sext;
    logic [31:0] rf_rs;
    logic [31:0] rf_rt;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_res;
    logic [31:0] pc_next;

    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign sext  = {{16{ir[15]}}, ir[15:0]};

    // Register 0 is hardwired to zero on the read side as well, so it
    // stays zero independent of what the array holds.
    assign rf_rs = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rf_rt = (rt == 5'd0) ? 32'd0 : rf[rt];

    assign wr_addr = RegDst ? rd : rt;
    assign wr_data = MemtoReg ? mdr : alu_out;

    assign alu_a = ALUSrcA ? a_reg : pc;

    always_comb begin
        alu_b = b_reg;
        case (ALUSrcB)
            2'b00:   alu_b = b_reg;
            2'b01:   alu_b = 32'd4;
            2'b10:   alu_b = sext;
            default: alu_b = {sext[29:0], 2'b00};
        endcase
    end

    // ALU control: unknown funct codes fall back to add
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (ALUOp)
            2'b01: alu_ctrl = ALU_SUB;
            2'b10: begin
                case (funct)
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_res = alu_a + alu_b;
        case (alu_ctrl)
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            ALU_SLT: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_res = alu_a + alu_b;
        endcase
    end

    // zero comes from the live ALU result so the branch state can commit
    // the PC in the same cycle it compares A and B.
    assign zero = (alu_res == 32'd0);

    always_comb begin
        pc_next = pc;
        case (PCSource)
            2'b00:   pc_next = alu_res;
            2'b01:   pc_next = alu_out;
            2'b10:   pc_next = {pc[31:28], ir[25:0], 2'b00};
            default: pc_next = pc;
        endcase
    end

    // Architectural registers. MDR, A, B and ALUOut capture every cycle;
    // the control unit only relies on them in the cycle after they were
    // meaningful.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= 32'd0;
            mdr     <= 32'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            alu_out <= 32'd0;
        end else begin
            mdr     <= mem.mem_rdata;
            a_reg   <= rf_rs;
            b_reg   <= rf_rt;
            alu_out <= alu_res;
            if (IRWrite) begin
                ir <= mem.mem_rdata;
            end
            if (PCWrite_F) begin
                pc <= pc_next;
            end
        end
    end

    // Register file. A and B sample the array above with the pre-write
    // contents, so a same-cycle write and read of one register yields the
    // old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'd0;
            end
        end else if (RegWrite && (wr_addr != 5'd0)) begin
            rf[wr_addr] <= wr_data;
        end
    end

    assign opcode = ir[31:26];
    assign pc_out = pc;

    assign mem.mem_addr  = IorD ? alu_out : pc;
    assign mem.mem_wdata = b_reg;
    assign mem.mem_we    = MemWrite & ~reset;
    assign mem.mem_re    = MemRead & ~reset;

endmodule
